// File: rtl/route_sched_pkg.sv
// Shared types and helpers for the route scheduler: FSM state encoding,
// source/select sizing and the dst_cfg field extractor.
package route_sched_pkg;

    localparam int SRC_COUNT = 4;
    localparam int SEL_W     = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // dst_cfg packs one 2-bit destination per source, source i at [2i+1:2i].
    function automatic logic [SEL_W-1:0] dst_field(
        input logic [2*SRC_COUNT-1:0] cfg,
        input logic [SEL_W-1:0]       src
    );
        return cfg[{src, 1'b0} +: SEL_W];
    endfunction

endpackage

// File: rtl/route_scheduler_pick.sv
// rr_pick4: combinational arbiter returning the first set request bit,
// searching upward from ptr with wrap 3->0, plus a valid flag.
module rr_pick4
    import route_sched_pkg::*;
(
    input  logic [SRC_COUNT-1:0] req,
    input  logic [SEL_W-1:0]     ptr,
    output logic [SEL_W-1:0]     idx,
    output logic                 valid
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = SRC_COUNT - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/route_scheduler.sv
// route_scheduler: grants one source->destination route of the nibble mux/demux
// for a bounded dwell window. Define ROUTE_SCHED_RR_EN for round-robin, else fixed priority.
module route_scheduler
    import route_sched_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = $clog2(DWELL_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SRC_COUNT-1:0]   req,
    input  logic [2*SRC_COUNT-1:0] dst_cfg,
    output logic [SEL_W-1:0]       mux_sel,
    output logic [SEL_W-1:0]       demux_sel,
    output logic                   route_en,
    output logic [SRC_COUNT-1:0]   grant,
    output logic                   busy,
    output logic                   done
);

    // Handshake: req bits are level requests, held by a source until served;
    // grant is the acceptance, and dropping req[winner] while ACTIVE ends the grant early.
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] win_idx;
    logic             win_valid;

`ifdef ROUTE_SCHED_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (state == RELEASE)
            ptr <= mux_sel + 1'b1;
    end
`else
    assign ptr = '0;
`endif

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (win_idx),
        .valid (win_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Early drop is tested before dwell expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_valid) state_nxt = SETTLE;
            SETTLE:  state_nxt = ACTIVE;
            ACTIVE: begin
                if (!req[mux_sel])
                    state_nxt = RELEASE;
                else if (cnt == '0)
                    state_nxt = RELEASE;
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Selects and counter load on entry to SETTLE, so they are stable before route_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mux_sel   <= '0;
            demux_sel <= '0;
            cnt       <= '0;
        end else begin
            if (state == IDLE && win_valid) begin
                mux_sel   <= win_idx;
                demux_sel <= dst_field(dst_cfg, win_idx);
                cnt       <= DWELL_LOAD;
            end else if (state == ACTIVE && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        route_en = 1'b0;
        grant    = '0;
        busy     = (state != IDLE);
        done     = (state == RELEASE);
        if (state == ACTIVE)
            route_en = 1'b1;
        if (state == SETTLE || state == ACTIVE)
            grant[mux_sel] = 1'b1;
    end

endmodule

// File: tb/tb_route_scheduler.sv
// Self-checking bench for route_scheduler (DWELL_CYCLES=4); adapts its
// arbitration model to whether ROUTE_SCHED_RR_EN is defined.
module tb_route_scheduler;

  localparam int DWELL = 4;
`ifdef ROUTE_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] dst_cfg;
  logic [1:0] mux_sel;
  logic [1:0] demux_sel;
  logic       route_en;
  logic [3:0] grant;
  logic       busy;
  logic       done;

  int n_chk;
  int n_fail;
  int cyc;
  int ptr_model;
  logic [1:0] prev_mux;
  logic [1:0] prev_dmx;
  logic [3:0] exp_q[$];

  route_scheduler #(.DWELL_CYCLES(DWELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dst_cfg   (dst_cfg),
    .mux_sel   (mux_sel),
    .demux_sel (demux_sel),
    .route_en  (route_en),
    .grant     (grant),
    .busy      (busy),
    .done      (done)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference arbitration: first requesting source at or after p, wrapping.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int off = 0; off < 4; off++)
      if (r[(p + off) % 4]) return (p + off) % 4;
    return -1;
  endfunction

  function automatic logic [1:0] field_of(input logic [7:0] cfg, input int src);
    logic [7:0] t;
    t = cfg >> (2 * src);
    return t[1:0];
  endfunction

  // Global invariants, sampled every cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("done_en_excl", {31'b0, done & route_en}, 0);
      check("sel_hold_en", {31'b0, route_en & ((mux_sel != prev_mux) | (demux_sel != prev_dmx))}, 0);
    end
    prev_mux = mux_sel;
    prev_dmx = demux_sel;
  end

  // Driver + per-grant timeline model. Called at a negedge while the DUT is IDLE.
  // drop_at in 1..DWELL drops req[winner] during that route_en cycle.
  task automatic run_grant(input logic [3:0] r, input logic [7:0] cfg, input int drop_at,
                           input bit scramble, output logic [3:0] obs_grant, output int settle_cyc);
    int w;
    int n_on;
    logic [1:0] exp_dst;
    logic [3:0] cur_req;
    cur_req    = r;
    req        = r;
    dst_cfg    = cfg;
    obs_grant  = 4'b0;
    settle_cyc = -1;
    w = pick(r, ptr_model);
    if (w < 0) begin
      @(negedge clk);
      check("noreq_busy", {31'b0, busy}, 0);
      check("noreq_grant", {28'b0, grant}, 0);
      return;
    end
    exp_dst = field_of(cfg, w);
    n_on = (drop_at >= 1 && drop_at <= DWELL) ? drop_at : DWELL;
    @(negedge clk);
    obs_grant  = grant;
    settle_cyc = cyc;
    check("settle_grant", {28'b0, grant}, 32'(1 << w));
    check("settle_mux", {30'b0, mux_sel}, 32'(w));
    check("settle_dmx", {30'b0, demux_sel}, {30'b0, exp_dst});
    check("settle_en", {31'b0, route_en}, 0);
    check("settle_busy", {31'b0, busy}, 1);
    for (int k = 1; k <= n_on; k++) begin
      @(negedge clk);
      check("active_en", {31'b0, route_en}, 1);
      check("active_grant", {28'b0, grant}, 32'(1 << w));
      check("active_dmx", {30'b0, demux_sel}, {30'b0, exp_dst});
      check("active_done", {31'b0, done}, 0);
      if (scramble) begin
        dst_cfg = (k == 1) ? ~cfg : 8'($urandom);
        cur_req = 4'($urandom);
        cur_req[w] = 1'b1;
        req = cur_req;
      end
      if (k == drop_at) begin
        cur_req[w] = 1'b0;
        req = cur_req;
      end
    end
    @(negedge clk);
    check("release_en", {31'b0, route_en}, 0);
    check("release_done", {31'b0, done}, 1);
    check("release_grant", {28'b0, grant}, 0);
    check("release_busy", {31'b0, busy}, 1);
    check("release_mux", {30'b0, mux_sel}, 32'(w));
    ptr_model = RR ? (w + 1) % 4 : 0;
    @(negedge clk);
    check("idle_busy", {31'b0, busy}, 0);
    check("idle_done", {31'b0, done}, 0);
    check("idle_en", {31'b0, route_en}, 0);
    check("idle_dmx", {30'b0, demux_sel}, {30'b0, exp_dst});
  endtask

  initial begin
    logic [3:0] g;
    int sc;
    int prev_sc;
    logic [7:0] cfg_now;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    ptr_model = 0;
    rst = 1'b1;
    req = 4'b0;
    dst_cfg = 8'b0;
    @(negedge clk);
    check("rst_mux", {30'b0, mux_sel}, 0);
    check("rst_dmx", {30'b0, demux_sel}, 0);
    check("rst_en", {31'b0, route_en}, 0);
    check("rst_grant", {28'b0, grant}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    @(negedge clk);
    rst = 1'b0;

    // All sources requesting: rotating grants in RR, always source 0 otherwise.
    if (RR) begin
      exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    end else begin
      repeat (5) exp_q.push_back(4'b0001);
    end
    prev_sc = -1;
    while (exp_q.size() > 0) begin
      run_grant(4'b1111, 8'hE4, 0, 1'b0, g, sc);
      check("all_req_seq", {28'b0, g}, {28'b0, exp_q.pop_front()});
      if (prev_sc >= 0) check("grant_spacing", 32'(sc - prev_sc), DWELL + 3);
      prev_sc = sc;
    end

    // Single request with a known destination map.
    run_grant(4'b0100, 8'b00_11_01_10, 0, 1'b0, g, sc);
    check("single_grant", {28'b0, g}, 32'b0100);
    check("single_dmx", {30'b0, demux_sel}, 3);

    // Early release on the 2nd route_en cycle, then no requests.
    run_grant(4'b0010, 8'h1B, 2, 1'b0, g, sc);
    run_grant(4'b0000, 8'h1B, 0, 1'b0, g, sc);
    check("no_regrant_src1", {28'b0, grant}, 0);

    // dst_cfg and other req bits scrambled mid-ACTIVE; next grant uses the new cfg.
    run_grant(4'b0100, 8'h00, 0, 1'b1, g, sc);
    cfg_now = dst_cfg;
    run_grant(4'b0100, cfg_now, 0, 1'b0, g, sc);
    check("cfg_resample", {30'b0, demux_sel}, {30'b0, field_of(cfg_now, 2)});

    // Async reset mid-ACTIVE, with the pointer moved off 0 beforehand.
    run_grant(4'b0010, 8'hA5, 0, 1'b0, g, sc);
    req = 4'b0100;
    dst_cfg = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_en", {31'b0, route_en}, 1);
    rst = 1'b1;
    #1;
    check("arst_mux", {30'b0, mux_sel}, 0);
    check("arst_dmx", {30'b0, demux_sel}, 0);
    check("arst_en", {31'b0, route_en}, 0);
    check("arst_grant", {28'b0, grant}, 0);
    check("arst_busy", {31'b0, busy}, 0);
    check("arst_done", {31'b0, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    ptr_model = 0;
    run_grant(4'b1001, 8'h6C, 0, 1'b0, g, sc);
    check("post_rst_grant", {28'b0, g}, 32'b0001);

    // Randomized requests, destinations, early drops and mid-grant noise.
    for (int n = 0; n < 40; n++) begin
      run_grant(4'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, DWELL + 1),
                1'($urandom_range(0, 1)), g, sc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
